// File: rtl/display_vramrd_if.sv
// AXI4 read-address / read-data channel bundle for the frame-buffer fetch.
// The fetch side is the master; the memory side is the slave.
interface display_vramrd_if;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  modport master (
    output M_AXI_ARADDR, M_AXI_ARLEN,
    output M_AXI_ARSIZE, M_AXI_ARBURST,
    output M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RDATA,
    input  M_AXI_RRESP, M_AXI_RLAST,
    input  M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_ARADDR, M_AXI_ARLEN,
    input  M_AXI_ARSIZE, M_AXI_ARBURST,
    input  M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RDATA,
    output M_AXI_RRESP, M_AXI_RLAST,
    output M_AXI_RVALID
  );
endinterface

// File: rtl/display_vramrd.sv
// Frame-buffer fetch: AXI4 INCR bursts over one frame into the pixel FIFO.
// One burst outstanding at a time, issued only when the FIFO has room for it.
module display_vramrd #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int BURST_LEN          = 16,
  parameter int FRAME_WORDS        = 153600,
  parameter int FIFO_DEPTH         = 1024,
  parameter int CNT_W              = 11
) (
  input  logic                          ACLK,
  input  logic                          ARST,
  input  logic [27:0]                   DISPADDR,
  input  logic                          DISPON,
  input  logic                          FRAME_START,
  input  logic [CNT_W-1:0]              FIFO_WRCNT,
  output logic                          FIFO_WR,
  output logic [C_M_AXI_DATA_WIDTH-1:0] FIFO_WDATA,
  output logic                          BUSY,
  output logic                          RDERR,
  output logic                          LATE,
  display_vramrd_if.master              axi
);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_ADDR, S_DATA
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] araddr_q, araddr_d;
  logic [17:0] words_q, words_d;
  logic [17:0] words_inc;
  logic        arvalid_q, arvalid_d;
  logic        wr_q, wr_d;
  logic        rderr_q, rderr_d;
  logic        late_q, late_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [31:0] fill;
  logic        has_room;
  logic        last_word;

  // The registered write still in flight has not reached FIFO_WRCNT yet.
  assign fill      = 32'(FIFO_WRCNT) + 32'(wr_q);
  assign has_room  = (fill + 32'(BURST_LEN)) <= 32'(FIFO_DEPTH);
  assign words_inc = words_q + 18'd1;
  assign last_word = words_inc == 18'(FRAME_WORDS);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    araddr_d  = araddr_q;
    words_d   = words_q;
    arvalid_d = arvalid_q;
    wr_d      = 1'b0;
    wdata_d   = wdata_q;
    rderr_d   = rderr_q;
    late_d    = late_q;
    if (FRAME_START && state_q != S_IDLE)
      late_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (FRAME_START && DISPON) begin
          base_d  = {4'b0, DISPADDR};
          words_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!DISPON) begin
          state_d = S_IDLE;
        end else if (has_room) begin
          araddr_d  = base_q + {12'b0, words_q, 2'b00};
          arvalid_d = 1'b1;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (axi.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (axi.M_AXI_RVALID) begin
          wr_d    = 1'b1;
          wdata_d = axi.M_AXI_RDATA;
          words_d = words_inc;
          if (axi.M_AXI_RRESP != 2'b00)
            rderr_d = 1'b1;
          if (axi.M_AXI_RLAST)
            state_d = (last_word || !DISPON) ?
                      S_IDLE : S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      araddr_q  <= '0;
      words_q   <= '0;
      arvalid_q <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rderr_q   <= 1'b0;
      late_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      araddr_q  <= araddr_d;
      words_q   <= words_d;
      arvalid_q <= arvalid_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      rderr_q   <= rderr_d;
      late_q    <= late_d;
    end
  end

  assign axi.M_AXI_ARADDR  = araddr_q;
  assign axi.M_AXI_ARLEN   = 8'(BURST_LEN - 1);
  assign axi.M_AXI_ARSIZE  = 3'b010;
  assign axi.M_AXI_ARBURST = 2'b01;
  assign axi.M_AXI_ARVALID = arvalid_q;
  assign axi.M_AXI_RREADY  = state_q == S_DATA;

  assign FIFO_WR    = wr_q;
  assign FIFO_WDATA = wdata_q;
  assign BUSY       = state_q != S_IDLE;
  assign RDERR      = rderr_q;
  assign LATE       = late_q;

endmodule
